// File: rtl/square_lookup_arbiter_if.sv
// Handshake bundle between the requesters, the shared square lookup and the response consumer.
interface square_lookup_arbiter_if;
  logic [3:0]  req;
  logic [15:0] n_in;
  logic [3:0]  sign_in;
  logic [3:0]  gnt;
  logic [3:0]  rom_n;
  logic        rom_sign;
  logic [7:0]  rom_square;
  logic        res_valid;
  logic [7:0]  res_square;
  logic        res_sign;
  logic [1:0]  res_id;
  logic        res_ack;
  logic        busy;

  modport master (
    output req, n_in, sign_in, rom_square, res_ack,
    input  gnt, rom_n, rom_sign, res_valid, res_square, res_sign, res_id, busy
  );

  modport slave (
    input  req, n_in, sign_in, rom_square, res_ack,
    output gnt, rom_n, rom_sign, res_valid, res_square, res_sign, res_id, busy
  );
endinterface

// File: rtl/square_lookup_arbiter.sv
// Round-robin arbiter sharing one square lookup among four requesters.
// 4-cycle service: IDLE arbitrates, GRANT, LOOKUP, RESP held until res_ack.
module square_lookup_arbiter #(
  parameter int NREQ = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  square_lookup_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] LOOKUP = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [3:0] gnt;
  logic [3:0] op_n;
  logic       op_sign;
  logic [1:0] op_id;
  logic       res_valid;
  logic [7:0] res_square;
  logic       res_sign;
  logic [1:0] res_id;

  logic [1:0] win_id;
  logic       win_vld;
  logic [1:0] idx;

  // First set request at or after ptr, wrapping.
  always_comb begin
    win_id  = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 4'd0;
      op_n       <= 4'd0;
      op_sign    <= 1'b0;
      op_id      <= 2'd0;
      res_valid  <= 1'b0;
      res_square <= 8'd0;
      res_sign   <= 1'b0;
      res_id     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= GRANT;
            gnt     <= 4'(4'b0001 << win_id);
            op_n    <= bus.n_in[4*win_id +: 4];
            op_sign <= bus.sign_in[win_id];
            op_id   <= win_id;
            ptr     <= win_id + 2'd1;
          end
        end
        GRANT: begin
          gnt   <= 4'd0;
          state <= LOOKUP;
        end
        LOOKUP: begin
          res_square <= bus.rom_square;
          res_sign   <= op_sign;
          res_id     <= op_id;
          res_valid  <= 1'b1;
          state      <= RESP;
        end
        default: begin
          if (bus.res_ack) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Operand registers drive the lookup directly, so it sees a full cycle of stable input.
  assign bus.rom_n      = op_n;
  assign bus.rom_sign   = op_sign;
  assign bus.gnt        = gnt;
  assign bus.res_valid  = res_valid;
  assign bus.res_square = res_square;
  assign bus.res_sign   = res_sign;
  assign bus.res_id     = res_id;
  assign bus.busy       = (state != IDLE);

endmodule
